// File: rtl/chip_droid_pkg.sv
// Shared constants for the chip_droid IO front end: sensor count, default
// debounce lengths and the sensor bit positions.
package chip_droid_pkg;

    localparam int NUM_SNS    = 4;
    localparam int DB_BTN_DEF = 1000;
    localparam int DB_SNS_DEF = 8;

    localparam int S1_IDX = 0;
    localparam int S2_IDX = 1;
    localparam int S3_IDX = 2;
    localparam int S4_IDX = 3;

endpackage

// File: rtl/debounce_ch.sv
// One conditioned input: 2-flop synchroniser, stability counter and a
// combinational flag that is high on the cycle before clean goes 0->1.
module debounce_ch #(
    parameter int DB = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise
);

    localparam int             CW   = $clog2(DB + 1);
    localparam logic [CW-1:0]  LAST = CW'(DB - 1);

    logic          sync1_reg;
    logic          sync_reg;
    logic [CW-1:0] cnt_reg;
    logic          clean_reg;

    // Asserted exactly when the next edge will move clean from 0 to 1.
    assign rise  = sync_reg & ~clean_reg & (cnt_reg == LAST);
    assign clean = clean_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync_reg  <= 1'b0;
            cnt_reg   <= '0;
            clean_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync_reg  <= sync1_reg;
            if (sync_reg == clean_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == LAST) begin
                clean_reg <= sync_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Conditions the mode button and obstacle sensors: debounced levels, a
// single-cycle press pulse and a sensor-valid flag after startup settling.
module input_conditioner
    import chip_droid_pkg::*;
#(
    parameter int DB_BTN = DB_BTN_DEF,
    parameter int DB_SNS = DB_SNS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               b_raw,
    input  logic [NUM_SNS-1:0] s_raw,
    output logic               b_level,
    output logic               b_pulse,
    output logic [NUM_SNS-1:0] s_clean,
    output logic               s_valid
);

    localparam int              START_MAX_I = DB_SNS + 2;
    localparam int              SCW         = $clog2(START_MAX_I + 1);
    localparam logic [SCW-1:0]  START_MAX   = SCW'(START_MAX_I);
    localparam logic [SCW-1:0]  START_LAST  = SCW'(START_MAX_I - 1);

    logic               btn_rise;
    logic [NUM_SNS-1:0] sns_rise_unused;
    logic               b_pulse_reg;
    logic               s_valid_reg;
    logic [SCW-1:0]     start_cnt_reg;

    debounce_ch #(.DB(DB_BTN)) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (b_raw),
        .clean (b_level),
        .rise  (btn_rise)
    );

    for (genvar gi = 0; gi < NUM_SNS; gi++) begin : g_sns
        debounce_ch #(.DB(DB_SNS)) u_sns (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (s_raw[gi]),
            .clean (s_clean[gi]),
            .rise  (sns_rise_unused[gi])
        );
    end

    // Pulse is registered on the same edge that raises b_level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_pulse_reg   <= 1'b0;
            s_valid_reg   <= 1'b0;
            start_cnt_reg <= '0;
        end else begin
            b_pulse_reg <= btn_rise;
            if (start_cnt_reg != START_MAX) begin
                start_cnt_reg <= start_cnt_reg + 1'b1;
            end
            if (start_cnt_reg == START_LAST) begin
                s_valid_reg <= 1'b1;
            end
        end
    end

    assign b_pulse = b_pulse_reg;
    assign s_valid = s_valid_reg;

endmodule
